// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit check for the BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int ITERS      = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int WORK_W     = BCD_W + BIN_W;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic nibble_invalid(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD nibble after a right shift.
module bcd_digit_adj (
  input  logic [3:0] nibble,
  output logic [3:0] adj
);

  assign adj = (nibble >= 4'd8) ? nibble - 4'd3 : nibble;

endmodule

// File: rtl/bcd3_to_bin.sv
// Three-digit BCD to 10-bit binary converter (reverse double-dabble, 10 shift steps).
// Optional invalid-digit detection is enabled by defining BCD3_TO_BIN_ERR_EN.
module bcd3_to_bin
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       units,
  output logic [BIN_W-1:0] bin_out,
  output logic             fits8,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t              state_reg, state_next;
  logic [WORK_W-1:0]   work_reg;
  logic [WORK_W-1:0]   work_shr;
  logic [WORK_W-1:0]   work_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                err_pend_reg;
  logic                accept;
  logic                bad_digits;

  logic [BIN_W-1:0]    bin_out_reg;
  logic                fits8_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_reg;

`ifdef BCD3_TO_BIN_ERR_EN
  assign bad_digits = nibble_invalid(hundreds) | nibble_invalid(tens) | nibble_invalid(units);
`else
  assign bad_digits = 1'b0;
`endif

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  // One step: shift the whole {bcd, bin} register right, then correct each BCD nibble.
  assign work_shr = work_reg >> 1;
  assign work_next[BIN_W-1:0] = work_shr[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .nibble (work_shr[BIN_W + 4*gi +: 4]),
        .adj    (work_next[BIN_W + 4*gi +: 4])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) state_next = bad_digits ? DONE : SHIFT;
        else       state_next = IDLE;
      end
      SHIFT: begin
        if (cnt_reg == CNT_W'(ITERS - 1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      work_reg     <= '0;
      cnt_reg      <= '0;
      err_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        work_reg     <= {hundreds, tens, units, {BIN_W{1'b0}}};
        cnt_reg      <= '0;
        err_pend_reg <= bad_digits;
      end else if (state_reg == SHIFT) begin
        work_reg <= work_next;
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

  // Outputs follow the state one cycle later; results only load out of DONE,
  // so they hold through any later SHIFT phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out_reg <= '0;
      fits8_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      busy_reg <= (state_reg == SHIFT);
      done_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        bin_out_reg <= err_pend_reg ? '0 : work_reg[BIN_W-1:0];
        fits8_reg   <= err_pend_reg || (work_reg[BIN_W-1:0] <= BIN_W'(255));
        err_reg     <= err_pend_reg;
      end
    end
  end

  assign bin_out = bin_out_reg;
  assign fits8   = fits8_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_bcd3_to_bin.sv
// Self-checking bench for bcd3_to_bin: directed corner cases plus random digits
// checked against decimal arithmetic (value = 100*h + 10*t + u).
module tb_bcd3_to_bin;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] hundreds = '0;
  logic [3:0] tens = '0;
  logic [3:0] units = '0;
  logic [9:0] bin_out;
  logic       fits8;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd3_to_bin dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .units    (units),
    .bin_out  (bin_out),
    .fits8    (fits8),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive a one-cycle start request; returns #1 after the sampling edge.
  task automatic launch(input int h, input int t, input int u);
    hundreds = 4'(h);
    tens     = 4'(t);
    units    = 4'(u);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the accepting edge until done appears (bounded).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convert(input int h, input int t, input int u, input string tag);
    int lat, bc, exp_v;
    logic [9:0] held;
    exp_v = 100 * h + 10 * t + u;
    launch(h, t, u);
    wait_done(lat, bc);
    $display("conv %s digits %0d,%0d,%0d -> bin_out=%0d fits8=%0d err=%0d latency=%0d busy=%0d (model %0d)",
             tag, h, t, u, bin_out, fits8, err, lat, bc, exp_v);
    check({tag, ".latency"}, lat, 11);
    check({tag, ".busy_cycles"}, bc, 10);
    check({tag, ".bin_out"}, 32'(bin_out), exp_v);
    check({tag, ".fits8"}, 32'(fits8), (exp_v <= 255) ? 1 : 0);
    check({tag, ".err"}, 32'(err), 0);
    held = bin_out;
    @(posedge clk);
    #1;
    check({tag, ".done_one_cycle"}, 32'(done), 0);
    check({tag, ".bin_out_hold"}, 32'(bin_out), 32'(held));
  endtask

  initial begin
    int lat, bc, seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.bin_out", 32'(bin_out), 0);
    check("reset.fits8", 32'(fits8), 1);
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.err", 32'(err), 0);
    rst_n = 1'b1;

    // Directed values and the 8-bit boundary
    convert(2, 5, 5, "d255");
    convert(9, 9, 9, "d999");
    convert(0, 0, 0, "d000");
    convert(2, 5, 6, "d256");

    // Start during SHIFT is ignored; start held in DONE is accepted back-to-back
    hundreds = 4'd1; tens = 4'd2; units = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        hundreds = 4'd4; tens = 4'd5; units = 4'd6; start = 1'b1;
      end else if (k == 4) begin
        start = 1'b0;
      end
      if (k == 10) start = 1'b1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    $display("conv ignore-start digits 1,2,3 -> bin_out=%0d latency=%0d (model 123)", bin_out, lat);
    check("ignore.latency", lat, 11);
    check("ignore.bin_out", 32'(bin_out), 123);
    check("ignore.fits8", 32'(fits8), 1);
    wait_done(lat, bc);
    $display("conv back-to-back digits 4,5,6 -> bin_out=%0d latency=%0d busy=%0d (model 456)", bin_out, lat, bc);
    check("b2b.latency", lat, 11);
    check("b2b.busy_cycles", bc, 10);
    check("b2b.bin_out", 32'(bin_out), 456);
    check("b2b.fits8", 32'(fits8), 0);
    @(posedge clk);
    #1;

    // Random digits against decimal arithmetic
    for (int i = 0; i < 16; i++) begin
      convert(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a conversion
    convert(7, 8, 9, "pre_reset");
    launch(3, 1, 4);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("conv reset-abort digits 3,1,4 -> bin_out=%0d fits8=%0d busy=%0d done=%0d err=%0d", bin_out, fits8, busy, done, err);
    check("abort.bin_out", 32'(bin_out), 0);
    check("abort.fits8", 32'(fits8), 1);
    check("abort.busy", 32'(busy), 0);
    check("abort.done", 32'(done), 0);
    check("abort.err", 32'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    check("abort.no_done_after_release", seen, 0);

    // Start on the first edge after reset release
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    convert(3, 4, 5, "first_edge");

`ifdef BCD3_TO_BIN_ERR_EN
    launch(1, 10, 0);
    wait_done(lat, bc);
    $display("conv invalid digits 1,A,0 -> bin_out=%0d fits8=%0d err=%0d latency=%0d", bin_out, fits8, err, lat);
    check("inv.latency", lat, 1);
    check("inv.busy_cycles", bc, 0);
    check("inv.err", 32'(err), 1);
    check("inv.bin_out", 32'(bin_out), 0);
    check("inv.fits8", 32'(fits8), 1);
    @(posedge clk);
    #1;
    convert(1, 0, 0, "after_inv");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd3_to_bin.md
BCD3_TO_BIN -- requirements
Module: bcd3_to_bin

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request conversion of the current digit inputs.
REQ-004 SHALL have port: hundreds  input  4  BCD hundreds digit.
REQ-005 SHALL have port: tens  input  4  BCD tens digit.
REQ-006 SHALL have port: units  input  4  BCD units digit.
REQ-007 SHALL have port: bin_out  output  10  binary result, range 0..999.
REQ-008 SHALL have port: fits8  output  1  high when bin_out <= 255.
REQ-009 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port: err  output  1  invalid-digit flag; meaningful only with the macro in REQ-027.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on an accepting edge it SHALL capture {hundreds,tens,units} into a 22-bit working register {bcd[11:0], bin[9:0]}, clear bin to 0, clear the iteration counter, and enter SHIFT.
REQ-014 SHALL, in SHIFT, on each edge shift the working register right by 1, then subtract 3 from every BCD nibble whose value is >= 8 (reverse double-dabble).
REQ-015 SHALL perform exactly 10 SHIFT iterations (counter 0..9), then enter DONE.
REQ-016 SHALL assert done for exactly one cycle in DONE, with bin_out, fits8 and err valid in that same cycle; this cycle SHALL be 11 clock cycles after the accepting edge.
REQ-017 SHALL return to IDLE after DONE unless start is high in DONE, in which case it SHALL accept the new request (back-to-back operation).
REQ-018 SHALL keep bin_out, fits8 and err stable from DONE until the next accepted start, and SHALL NOT update them during SHIFT.
REQ-019 SHALL assert busy in SHIFT only; busy SHALL be low in IDLE and DONE.
REQ-020 SHALL ignore start while busy: no restart, no change to the captured operands.
REQ-021 SHALL compute fits8 as (result <= 255); 255 -> fits8=1, 256 -> fits8=0.
REQ-022 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while rst_n is low, force state=IDLE, bin_out=0, fits8=1, busy=0, done=0, err=0, and clear the working register and counter.
REQ-024 SHALL, when reset asserts mid-conversion, abort the conversion immediately; no done pulse SHALL follow reset release without a new start.
REQ-025 SHALL, on the first edge after reset release, evaluate start normally.

Configuration
REQ-026 SHALL keep the same port list whether or not the macro in REQ-027 is defined.
REQ-027 SHALL, with BCD3_TO_BIN_ERR_EN defined, check the captured nibbles on accept; if any nibble > 9, it SHALL skip SHIFT and enter DONE on the next edge (done 1 cycle after accept) with err=1, bin_out=0 and fits8=1.
REQ-028 SHALL, without BCD3_TO_BIN_ERR_EN, tie err to 0, omit the check, and convert invalid nibbles by the algorithm unchanged, with an unspecified result.

Structure
REQ-029 SHALL take the following from the shared package bcd_pkg: BCD_DIGITS=3, BIN_W=10, ITERS=10, and the state enum typedef (IDLE, SHIFT, DONE).
REQ-030 SHALL use sub-module bcd_digit_adj (combinational: nibble >= 8 ? nibble-3 : nibble), instantiated once per digit.

Verification
REQ-031 SHALL check: digits 2,5,5 + start pulse -> done 11 cycles later, bin_out=0x0FF, fits8=1, busy high for 10 cycles.
REQ-032 SHALL check: digits 9,9,9 -> bin_out=0x3E7, fits8=0; digits 0,0,0 -> bin_out=0, fits8=1.
REQ-033 SHALL check: start 1,2,3, then start 4,5,6 at cycle 4 -> result 0x07B only; then start held high in DONE -> 4,5,6 accepted back-to-back -> 0x1C8.
REQ-034 SHALL check: rst_n low at cycle 5 of a conversion -> all outputs at reset values, no done pulse afterwards.
REQ-035 SHALL check: with BCD3_TO_BIN_ERR_EN, digits 1,A,0 -> done 1 cycle after accept, err=1, bin_out=0; next valid request clears err.
REQ-036 SHALL check: digits 2,5,6 -> bin_out=0x100, fits8=0 (boundary).
